// File: rtl/accum_ctrl_pkg.sv
// Shared types and constants for the accumulate controller and its datapath.
// Holds the FSM state encoding and the datapath mux-select codes.
package accum_ctrl_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_ADD,
    ST_DONE
  } state_e;

  localparam logic [SEL_W-1:0] SEL_CLEAR = 2'b00;
  localparam logic [SEL_W-1:0] SEL_LOAD  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_ADD   = 2'b10;
  localparam logic [SEL_W-1:0] SEL_HOLD  = 2'b11;

endpackage

// File: rtl/add_counter4.sv
// 4-bit addition counter with synchronous clear/enable and a terminal compare.
// The count never moves past the limit, so it cannot wrap.
module add_counter4
  import accum_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc_o    = (count_q == limit_i);
  assign count_o = count_q;

  // Clear takes priority; increment is blocked once the limit is reached.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/accum_controller.sv
// Sequencer for an accumulate datapath: clear, load A, then add A up to
// max_adds times, stopping early if the running sum would reach bit 7.
module accum_controller
  import accum_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] max_adds_i,
  input  logic             fgt127_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] add_count_o
);

  state_e           state_q;
  logic [CNT_W-1:0] max_q;
  logic             busy_q;
  logic             done_q;
  logic             overflow_q;

  logic             start_ok;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt;

  assign start_ok = (state_q == ST_IDLE) && start_i;

  // Count-reached is checked before fgt127 so a full run never flags overflow.
  always_comb begin
    cnt_clr = start_ok;
    cnt_en  = (state_q == ST_ADD) && !cnt_tc && !fgt127_i;
  end

  always_comb begin
    sel_o = SEL_HOLD;
    case (state_q)
      ST_CLEAR: sel_o = SEL_CLEAR;
      ST_LOAD:  sel_o = SEL_LOAD;
      ST_ADD:   sel_o = cnt_en ? SEL_ADD : SEL_HOLD;
      default:  sel_o = SEL_HOLD;
    endcase
  end

  add_counter4 u_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (max_q),
    .count_o (cnt),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      max_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_CLEAR;
            max_q      <= max_adds_i;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_CLEAR: state_q <= ST_LOAD;
        ST_LOAD:  state_q <= ST_ADD;
        ST_ADD: begin
          if (cnt_tc || fgt127_i) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!cnt_tc) begin
              overflow_q <= 1'b1;
            end
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign overflow_o  = overflow_q;
  assign add_count_o = cnt;

endmodule

// File: tb/tb_accum_controller.sv
// Bench for accum_controller with a small accumulator datapath model and a
// done-driven scoreboard fed by an arithmetic reference of each sequence.
module tb_accum_controller;
  import accum_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] max_adds;
  logic       fgt127;
  logic [1:0] sel;
  logic       busy, done, overflow;
  logic [3:0] add_count;
  logic [7:0] a, f_q, sum;

  typedef struct {
    logic [7:0] f;
    int         n;
    logic       ovf;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [1:0] trace[$];
  logic       prev_done = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  accum_controller dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .max_adds_i  (max_adds),
    .fgt127_i    (fgt127),
    .sel_o       (sel),
    .busy_o      (busy),
    .done_o      (done),
    .overflow_o  (overflow),
    .add_count_o (add_count)
  );

  // Accumulator datapath driven by sel.
  assign sum    = a + f_q;
  assign fgt127 = sum[7];
  always @(posedge clk or posedge rst) begin
    if (rst) f_q <= 8'd0;
    else begin
      case (sel)
        2'b00:   f_q <= 8'd0;
        2'b01:   f_q <= a;
        2'b10:   f_q <= sum;
        default: f_q <= f_q;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Reference: add A while fewer than max adds are done and A+F stays below 128.
  task automatic push_exp(input int av, input int mv);
    exp_t e;
    int f = av;
    int n = 0;
    while (n < mv && ((av + f) & 128) == 0) begin
      f += av;
      n++;
    end
    e.f   = 8'(f);
    e.n   = n;
    e.ovf = (n < mv);
    exp_q.push_back(e);
  endtask

  // Monitor: record sel while busy, score the sequence on each done pulse.
  always @(negedge clk) begin
    if (rst) begin
      trace.delete();
      prev_done <= 1'b0;
    end else begin
      if (prev_done) check("done_one_cycle", int'(done), 0);
      prev_done <= done;
      if (busy) begin
        if (trace.size() == 0) begin
          check("start_clears_ovf", int'(overflow), 0);
          check("start_clears_cnt", int'(add_count), 0);
        end
        trace.push_back(sel);
        if (trace.size() > 24) begin
          check("busy_bound", trace.size(), 24);
          trace.delete();
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          int bad = -1;
          mon_e = exp_q.pop_front();
          check("latency", trace.size() + 1, mon_e.n + 4);
          foreach (trace[i]) begin
            int want;
            want = (i == 0) ? 0 : (i == 1) ? 1 : (i < mon_e.n + 2) ? 2 : 3;
            if (int'(trace[i]) != want && bad < 0) bad = i;
          end
          check("sel_trace_bad_idx", bad, -1);
          check("result_f", int'(f_q), int'(mon_e.f));
          check("add_count", int'(add_count), mon_e.n);
          check("overflow", int'(overflow), int'(mon_e.ovf));
          check("busy_in_done", int'(busy), 0);
          check("sel_in_done", int'(sel), 3);
        end
        trace.delete();
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sel"}, int'(sel), 3);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cnt"}, int'(add_count), 0);
  endtask

  task automatic run_seq(input int av, input int mv);
    @(negedge clk);
    a        = 8'(av);
    max_adds = 4'(mv);
    start    = 1'b1;
    @(posedge clk);
    #1;
    check("accept", int'(busy), 1);
    push_exp(av, mv);
    start    = 1'b0;
    max_adds = 4'($urandom_range(0, 15));
    wait_idle(40);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'd0; max_adds = 4'd0;
    repeat (2) @(negedge clk);
    check_idle("in_reset");
    check("in_reset_ovf", int'(overflow), 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("idle");
    end

    run_seq(5, 3);
    run_seq(15, 15);
    @(negedge clk);
    check("ovf_sticky", int'(overflow), 1);
    run_seq(9, 0);
    run_seq(40, 2);
    run_seq(0, 15);

    // Abort mid-ADD with an asynchronous reset.
    @(negedge clk);
    a = 8'd3; max_adds = 4'd10; start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_accept", int'(busy), 1);
    push_exp(3, 10);
    start = 1'b0;
    begin
      int k = 0;
      while (add_count != 4'd2 && k < 30) begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    check("abort_reach2", int'(add_count), 2);
    #2 rst = 1'b1;
    #1;
    check_idle("abort");
    check("abort_ovf", int'(overflow), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_idle("post_abort");
    end
    run_seq(3, 10);

    // start held high across a sequence with max_adds changed after capture.
    @(negedge clk);
    a = 8'd7; max_adds = 4'd2; start = 1'b1;
    @(posedge clk);
    #1;
    check("hold_accept", int'(busy), 1);
    push_exp(7, 2);
    max_adds = 4'd9;
    wait_idle(40);
    push_exp(7, 9);
    @(posedge clk);
    #1;
    check("hold_idle_gap", int'(busy), 0);
    @(posedge clk);
    #1;
    check("hold_reaccept", int'(busy), 1);
    start = 1'b0;
    wait_idle(40);

    for (int i = 0; i < 20; i++) begin
      run_seq(int'($urandom_range(0, 60)), int'($urandom_range(0, 15)));
    end

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
